des_req_ctrl: RTL

//  Host-side initiator for des_core. Accepts encrypt/decrypt jobs on a valid/ready port.

---
 rtl/des_req_ctrl_if.sv | 38 +++
 rtl/des_req_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/des_req_ctrl_if.sv
// Host-side job/result handshake bundle for des_req_ctrl.
// The master side (bus/register layer) issues jobs and consumes results;
// the slave side (the controller) accepts jobs and produces results.
interface des_req_ctrl_if;
    logic        job_valid;
    logic        job_ready;
    logic        job_mode;
    logic [63:0] job_data;
    logic [63:0] job_key;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_err;

    modport master (
        output job_valid,
        output job_mode,
        output job_data,
        output job_key,
        output res_ready,
        input  job_ready,
        input  res_valid,
        input  res_data,
        input  res_err
    );

    modport slave (
        input  job_valid,
        input  job_mode,
        input  job_data,
        input  job_key,
        input  res_ready,
        output job_ready,
        output res_valid,
        output res_data,
        output res_err
    );
endinterface

// File: rtl/des_req_ctrl.sv
// des_req_ctrl: host-side initiator for des_core.
// Accepts one encrypt/decrypt job at a time, holds data/key stable towards the
// core, fires a single-cycle enable, waits for a rising edge on core_ready and
// returns the captured result. A watchdog ends the wait after TIMEOUT cycles
// and reports an error result instead. TIMEOUT is expected to be >= 20.
module des_req_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    des_req_ctrl_if.slave      host,
    output logic               core_encipher_en,
    output logic               core_decipher_en,
    output logic [63:0]        core_data,
    output logic [63:0]        core_key,
    input  logic [63:0]        core_result,
    input  logic               core_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   job_cnt
);

    // Timer only has to reach TIMEOUT-1 before the watchdog fires.
    localparam int unsigned       TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic               job_ready_r;
    logic               busy_r;
    logic               enc_en_r;
    logic               dec_en_r;
    logic [63:0]        core_data_r;
    logic [63:0]        core_key_r;
    logic               mode_q_r;
    logic [TMR_W-1:0]   timer_r;
    logic               res_valid_r;
    logic [63:0]        res_data_r;
    logic               res_err_r;
    logic [CNT_W-1:0]   job_cnt_r;
    logic               core_ready_q_r;

    logic               accept_s;
    logic               done_s;
    logic               timeout_s;

    // A job is taken only while the controller advertises ready (IDLE).
    assign accept_s  = host.job_valid & job_ready_r;
    // Completion is a fresh rising edge, so a level left high by an earlier
    // job (or raised during ISSUE) can never complete the current one.
    assign done_s    = core_ready & ~core_ready_q_r;
    assign timeout_s = (timer_r == TMR_LAST);

    assign host.job_ready   = job_ready_r;
    assign host.res_valid   = res_valid_r;
    assign host.res_data    = res_data_r;
    assign host.res_err     = res_err_r;
    assign core_encipher_en = enc_en_r;
    assign core_decipher_en = dec_en_r;
    assign core_data        = core_data_r;
    assign core_key         = core_key_r;
    assign busy             = busy_r;
    assign job_cnt          = job_cnt_r;

    // One-cycle delay of core_ready for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready_q_r <= 1'b0;
        end else begin
            core_ready_q_r <= core_ready;
        end
    end

    // Request FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            job_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            enc_en_r    <= 1'b0;
            dec_en_r    <= 1'b0;
            core_data_r <= 64'd0;
            core_key_r  <= 64'd0;
            mode_q_r    <= 1'b0;
            timer_r     <= {TMR_W{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= 64'd0;
            res_err_r   <= 1'b0;
            job_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        core_data_r <= host.job_data;
                        core_key_r  <= host.job_key;
                        mode_q_r    <= host.job_mode;
                        // Enables are registered: loading them here makes the
                        // pulse coincide exactly with the ISSUE cycle. The
                        // mode used is the one latched into mode_q_r.
                        enc_en_r    <= ~host.job_mode;
                        dec_en_r    <= host.job_mode;
                        job_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end else begin
                        job_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        enc_en_r    <= 1'b0;
                        dec_en_r    <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    enc_en_r <= 1'b0;
                    dec_en_r <= 1'b0;
                    timer_r  <= {TMR_W{1'b0}};
                    state_r  <= ST_WAIT;
                end

                ST_WAIT: begin
                    // done is tested first so a coincident timeout succeeds.
                    if (done_s) begin
                        res_data_r  <= core_result;
                        res_err_r   <= 1'b0;
                        res_valid_r <= 1'b1;
                        job_cnt_r   <= job_cnt_r + CNT_W'(1);
                        state_r     <= ST_RESP;
                    end else if (timeout_s) begin
                        res_data_r  <= 64'd0;
                        res_err_r   <= 1'b1;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end

                ST_RESP: begin
                    if (host.res_ready) begin
                        res_valid_r <= 1'b0;
                        job_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end

                default: begin
                    enc_en_r    <= 1'b0;
                    dec_en_r    <= 1'b0;
                    res_valid_r <= 1'b0;
                    job_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
